// File: rtl/roll_sequencer.sv
// Roll sequencer: turns a roll request into a roll_en strobe train for the dice manager.
// Define ROLL_SEQUENCER_ANIM_EN for the animated multi-tick roll; otherwise a single-strobe FIRE roll.
`timescale 1ns/1ps
module roll_sequencer #(
  parameter int TICK_DIV   = 2500000,
  parameter int ANIM_TICKS = 10,
  parameter int MAX_ROLLS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic       turn_start,
  input  logic [4:0] hold_sw,
  output logic       roll_en,
  output logic [4:0] hold_mask,
  output logic [1:0] rolls_left,
  output logic       busy,
  output logic       roll_done,
  output logic       can_score
);

  if (TICK_DIV < 2 || ANIM_TICKS < 1 || MAX_ROLLS < 1 || MAX_ROLLS > 3) begin : g_bad_params
    $error("roll_sequencer: parameter out of range");
  end

  localparam logic [1:0] ROLLS_INIT = 2'(MAX_ROLLS);

`ifdef ROLL_SEQUENCER_ANIM_EN
  typedef enum logic [1:0] {IDLE, ANIM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FIRE, DONE} state_t;
`endif

  state_t state_q, state_d;
  logic   accept;

`ifdef ROLL_SEQUENCER_ANIM_EN
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(ANIM_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(ANIM_TICKS - 1);

  logic [TW-1:0] tick_q;
  logic [PW-1:0] pulse_q;
  logic          tick_hit;

  // Strobe is decoded from registered state, so it lands TICK_DIV cycles after each wrap.
  assign tick_hit = (state_q == ANIM) && (tick_q == TICK_LAST);
  assign roll_en  = tick_hit;
`else
  assign roll_en  = (state_q == FIRE);
`endif

  assign busy      = (state_q != IDLE);
  assign roll_done = (state_q == DONE);
  assign can_score = (rolls_left < ROLLS_INIT) && !busy;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (roll_req && !turn_start && (rolls_left != 2'd0)) begin
          accept  = 1'b1;
`ifdef ROLL_SEQUENCER_ANIM_EN
          state_d = ANIM;
`else
          state_d = FIRE;
`endif
        end
      end
`ifdef ROLL_SEQUENCER_ANIM_EN
      ANIM: if (tick_hit && (pulse_q == PULSE_LAST)) state_d = DONE;
`else
      FIRE: state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (turn_start) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_mask  <= 5'b00000;
      rolls_left <= ROLLS_INIT;
    end else begin
      state_q <= state_d;
      if (turn_start) begin
        rolls_left <= ROLLS_INIT;
      end else if ((state_q == DONE) && (rolls_left != 2'd0)) begin
        rolls_left <= rolls_left - 2'd1;
      end
      // The first roll of a turn always rolls all five dice.
      if (accept) hold_mask <= (rolls_left == ROLLS_INIT) ? 5'b00000 : hold_sw;
    end
  end

`ifdef ROLL_SEQUENCER_ANIM_EN
  always_ff @(posedge clk) begin
    if (reset || (state_q != ANIM)) begin
      tick_q  <= '0;
      pulse_q <= '0;
    end else begin
      tick_q <= tick_hit ? '0 : tick_q + 1'b1;
      if (tick_hit) pulse_q <= pulse_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_roll_sequencer.sv
// Bench for roll_sequencer: table of rolls plus hand-written abort, reset and collision sequences.
// Strobe and done cycles are predicted into queues and matched as the DUT produces them.
`timescale 1ns/1ps
module tb_roll_sequencer;
  localparam int TD = 4;
  localparam int AT = 3;
  localparam int MR = 3;
`ifdef ROLL_SEQUENCER_ANIM_EN
  localparam int ABORT_AT = 6;
  localparam int RESET_AT = 5;
`else
  localparam int ABORT_AT = 1;
  localparam int RESET_AT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       roll_req = 1'b0;
  logic       turn_start = 1'b0;
  logic [4:0] hold_sw = 5'b00000;
  logic       roll_en;
  logic [4:0] hold_mask;
  logic [1:0] rolls_left;
  logic       busy;
  logic       roll_done;
  logic       can_score;

  roll_sequencer #(.TICK_DIV(TD), .ANIM_TICKS(AT), .MAX_ROLLS(MR)) dut (
    .clk(clk), .reset(reset), .roll_req(roll_req), .turn_start(turn_start),
    .hold_sw(hold_sw), .roll_en(roll_en), .hold_mask(hold_mask),
    .rolls_left(rolls_left), .busy(busy), .roll_done(roll_done), .can_score(can_score)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] done_q[$];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic       ts;
    logic [4:0] hs;
    logic [4:0] mask;
    logic [1:0] rolls;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event at cycle %0d, expected none", name, cyc);
  endtask

  // One clock cycle; strobes are matched at the falling edge.
  task automatic step();
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      check("roll_en_missed", exp_q[0], cyc);
      void'(exp_q.pop_front());
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      check("roll_done_missed", done_q[0], cyc);
      void'(done_q.pop_front());
    end
    if (roll_en) begin
      if (exp_q.size() == 0) fail_event("roll_en_unexpected");
      else check("roll_en_cycle", 32'(cyc), exp_q.pop_front());
    end
    if (roll_done) begin
      if (done_q.size() == 0) fail_event("roll_done_unexpected");
      else check("roll_done_cycle", 32'(cyc), done_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_roll(input int n);
`ifdef ROLL_SEQUENCER_ANIM_EN
    for (int k = 1; k <= AT; k++) exp_q.push_back(32'(n + k * TD));
    done_q.push_back(32'(n + AT * TD + 1));
`else
    exp_q.push_back(32'(n + 1));
    done_q.push_back(32'(n + 2));
`endif
  endtask

  // Strobes up to and including cycle n+last, for a roll cut short at that cycle.
  task automatic expect_partial(input int n, input int last);
`ifdef ROLL_SEQUENCER_ANIM_EN
    for (int k = 1; k <= AT; k++) if (k * TD <= last) exp_q.push_back(32'(n + k * TD));
`else
    if (last >= 1) exp_q.push_back(32'(n + 1));
`endif
  endtask

  // driver tasks
  task automatic do_roll(input logic [4:0] hs, input logic accepted, output int n);
    hold_sw  = hs;
    roll_req = 1'b1;
    n = cyc;
    if (accepted) expect_roll(n);
    step();
    roll_req = 1'b0;
  endtask

  task automatic pulse_turn();
    turn_start = 1'b1;
    step();
    turn_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_roll_en"}, 32'(roll_en), 32'd0);
    check({tag, "_roll_done"}, 32'(roll_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hold_mask"}, 32'(hold_mask), 32'd0);
    check({tag, "_rolls_left"}, 32'(rolls_left), 32'(MR));
    check({tag, "_can_score"}, 32'(can_score), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 5'b10101, 5'b00000, 2'd2};
    vecs[1] = '{1'b0, 5'b10101, 5'b10101, 2'd1};
    vecs[2] = '{1'b0, 5'b01010, 5'b01010, 2'd0};
    vecs[3] = '{1'b1, 5'b11111, 5'b00000, 2'd2};
    vecs[4] = '{1'b0, 5'b00011, 5'b00011, 2'd1};

    @(posedge clk);
    #1;
    step_n(2);
    reset = 1'b0;
    check_reset_outputs("reset");

    // Table of complete rolls, each with a repeated request while busy.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].ts) begin
        pulse_turn();
        check("turn_rolls_left", 32'(rolls_left), 32'(MR));
        check("turn_can_score", 32'(can_score), 32'd0);
      end
      do_roll(vecs[i].hs, 1'b1, n);
      check("roll_busy", 32'(busy), 32'd1);
      check("roll_can_score_busy", 32'(can_score), 32'd0);
      roll_req = 1'b1;
      step();
      roll_req = 1'b0;
      wait_idle(100);
      check("roll_hold_mask", 32'(hold_mask), 32'(vecs[i].mask));
      check("roll_rolls_left", 32'(rolls_left), 32'(vecs[i].rolls));
      check("roll_can_score", 32'(can_score), 32'd1);
      check("roll_en_count", 32'(exp_q.size()), 32'd0);
    end

    // Use up the turn, then a request with no rolls left.
    do_roll(5'b00111, 1'b1, n);
    wait_idle(100);
    check("last_rolls_left", 32'(rolls_left), 32'd0);
    do_roll(5'b11000, 1'b0, n);
    check("empty_busy", 32'(busy), 32'd0);
    step_n(6);
    check("empty_rolls_left", 32'(rolls_left), 32'd0);
    check("empty_can_score", 32'(can_score), 32'd1);
    check("empty_hold_mask", 32'(hold_mask), 32'(5'b00111));

    // turn_start aborts a roll in flight; hold_mask is kept.
    pulse_turn();
    do_roll(5'b00000, 1'b1, n);
    wait_idle(100);
    do_roll(5'b01100, 1'b0, n);
    expect_partial(n, ABORT_AT);
    while (cyc < n + ABORT_AT) step();
    turn_start = 1'b1;
    step();
    turn_start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rolls_left", 32'(rolls_left), 32'(MR));
    check("abort_hold_mask", 32'(hold_mask), 32'(5'b01100));
    check("abort_can_score", 32'(can_score), 32'd0);
    step_n(16);
    check("abort_queue_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

    // turn_start and roll_req together: the roll is dropped.
    turn_start = 1'b1;
    roll_req   = 1'b1;
    hold_sw    = 5'b11111;
    step();
    turn_start = 1'b0;
    roll_req   = 1'b0;
    check("collide_busy", 32'(busy), 32'd0);
    check("collide_rolls_left", 32'(rolls_left), 32'(MR));
    step_n(6);
    check("collide_busy_later", 32'(busy), 32'd0);

    // Reset in the middle of a roll.
    do_roll(5'b00000, 1'b1, n);
    wait_idle(100);
    do_roll(5'b11001, 1'b0, n);
    expect_partial(n, RESET_AT);
    while (cyc < n + RESET_AT) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_outputs("midreset");
    step_n(16);
    check("midreset_queue_empty", 32'(exp_q.size() + done_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
